// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over a 128 x 16-bit word memory.
// Latency: response valid 1+WAIT_CYCLES edges after the accept edge.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [7:0]  req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic [2:0]  rsp_cc,
   output logic        rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // The counter is 4 bits wide, so WAIT_CYCLES above 15 cannot be represented.
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        we_q;
   logic [7:0]  addr_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic [2:0]  rsp_cc_q;
   logic        rsp_err_q;

   // Contents are never reset; they power up as all zeros.
   logic [15:0] mem_q [0:127] = '{default: 16'h0000};

   logic        accept;
   logic        addr_oor;
   logic [15:0] rd_word;
   logic [2:0]  rd_cc;

   // A request is taken only in IDLE; req_valid in any other state is ignored.
   assign accept   = req_valid && (state_q == S_IDLE);
   // Bit 7 set means 128..255: flagged as an error, never folded onto 0..127.
   assign addr_oor = addr_q[7];
   assign rd_word  = mem_q[addr_q[6:0]];

   // Condition codes of the word being returned: exactly one of N/Z/P is set.
   always_comb begin
      rd_cc = 3'b000;
      if (rd_word[15])
         rd_cc = 3'b100;
      else if (rd_word == 16'h0000)
         rd_cc = 3'b010;
      else
         rd_cc = 3'b001;
   end

   // Store commits on the accept edge; out-of-range stores and reset leave memory alone.
   always_ff @(posedge CLOCK_50) begin
      if (RESET_N && accept && req_we && !req_addr[7])
         mem_q[req_addr[6:0]] <= req_wdata;
   end

   // Request/response FSM. Every accept passes through WAIT, which lasts
   // WAIT_CYCLES+1 edges (a single edge when WAIT_CYCLES is 0), giving RESP
   // after edge T+1+WAIT_CYCLES. All interface outputs are registered here.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         addr_q      <= 8'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 16'h0000;
         rsp_cc_q    <= 3'b000;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q        <= req_we;
                  addr_q      <= req_addr;
                  cnt_q       <= WAIT_INIT;
                  req_ready_q <= 1'b0;
                  state_q     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= S_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= addr_oor;
                  // Only an in-range load returns data; the read sees any
                  // store that committed on an earlier edge.
                  if (!we_q && !addr_oor) begin
                     rsp_rdata_q <= rd_word;
                     rsp_cc_q    <= rd_cc;
                  end else begin
                     rsp_rdata_q <= 16'h0000;
                     rsp_cc_q    <= 3'b000;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               // A request in the handshake cycle is not taken: req_ready is
               // still 0 and only rises after this edge.
               if (rsp_ready) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= 16'h0000;
                  rsp_cc_q    <= 3'b000;
                  rsp_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               cnt_q       <= 4'd0;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_rdata_q <= 16'h0000;
               rsp_cc_q    <= 3'b000;
               rsp_err_q   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_cc    = rsp_cc_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 responder and a WAIT_CYCLES=0 responder
// share one request/response stimulus stream and are checked in lockstep.
// Each step carries hand-computed expected data, cc, err and latency.
module tb_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_ready;

   logic        req_ready,  rsp_valid,  rsp_err;
   logic [15:0] rsp_rdata;
   logic [2:0]  rsp_cc;
   logic        req_ready0, rsp_valid0, rsp_err0;
   logic [15:0] rsp_rdata0;
   logic [2:0]  rsp_cc0;

   int checks = 0;
   int errors = 0;

   mem_responder #(.WAIT_CYCLES(2)) u_dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_cc   (rsp_cc),
      .rsp_err  (rsp_err)
   );

   mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready0),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid0),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata0),
      .rsp_cc   (rsp_cc0),
      .rsp_err  (rsp_err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full transaction through both DUTs; latency counted in edges after accept.
   task automatic txn(input string tag, input logic we, input logic [7:0] a,
                      input logic [15:0] wd, input logic [15:0] exp_d,
                      input logic [2:0] exp_cc, input logic exp_err);
      int n;
      int n0;
      @(negedge clk);
      chk({tag, " req_ready"}, req_ready, 1);
      chk({tag, " req_ready0"}, req_ready0, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n  = 0;
      n0 = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (rsp_valid0 && n0 == 0) n0 = n;
      end
      chk({tag, " latency"}, n, 3);
      chk({tag, " latency0"}, n0, 1);
      chk({tag, " rdata"}, rsp_rdata, exp_d);
      chk({tag, " cc"}, rsp_cc, exp_cc);
      chk({tag, " err"}, rsp_err, exp_err);
      chk({tag, " rdata0"}, rsp_rdata0, exp_d);
      chk({tag, " cc0"}, rsp_cc0, exp_cc);
      chk({tag, " err0"}, rsp_err0, exp_err);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, " post rsp_valid"}, {rsp_valid, rsp_valid0}, 0);
      chk({tag, " post req_ready"}, {req_ready, req_ready0}, 2'b11);
      chk({tag, " post fields"}, {rsp_rdata, rsp_cc, rsp_err}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  n;
      logic stable;
      logic seen;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 8'd0;
      req_wdata = 16'h0000;
      rsp_ready = 1'b0;
      #23;
      chk("reset rsp_valid", {rsp_valid, rsp_valid0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset req_ready", {req_ready, req_ready0}, 2'b11);
      chk("reset rdata", rsp_rdata, 16'h0000);
      chk("reset cc", rsp_cc, 3'b000);
      chk("reset err", rsp_err, 1'b0);

      txn("st5",     1'b1, 8'd5,   16'h8001, 16'h0000, 3'b000, 1'b0);
      txn("ld5",     1'b0, 8'd5,   16'h0000, 16'h8001, 3'b100, 1'b0);
      txn("ld10",    1'b0, 8'd10,  16'h0000, 16'h0000, 3'b010, 1'b0);
      txn("st10",    1'b1, 8'd10,  16'h0007, 16'h0000, 3'b000, 1'b0);
      txn("ld10b",   1'b0, 8'd10,  16'h0000, 16'h0007, 3'b001, 1'b0);
      txn("ld72",    1'b0, 8'd72,  16'h0000, 16'h0000, 3'b010, 1'b0);
      txn("st200",   1'b1, 8'd200, 16'h1234, 16'h0000, 3'b000, 1'b1);
      txn("ld72b",   1'b0, 8'd72,  16'h0000, 16'h0000, 3'b010, 1'b0);
      txn("ld128",   1'b0, 8'd128, 16'h0000, 16'h0000, 3'b000, 1'b1);
      txn("st127",   1'b1, 8'd127, 16'h0042, 16'h0000, 3'b000, 1'b0);
      txn("ld127",   1'b0, 8'd127, 16'h0000, 16'h0042, 3'b001, 1'b0);

      // Response held for 5 cycles while a second request is pending.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'd5;
      @(posedge clk); #1;
      req_addr  = 8'd10;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("hold latency", n, 3);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (!rsp_valid || rsp_rdata !== 16'h8001 || rsp_cc !== 3'b100 ||
             rsp_err !== 1'b0 || req_ready !== 1'b0 || req_ready0 !== 1'b0)
            stable = 1'b0;
      end
      chk("hold stable", stable, 1'b1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("hold release req_ready", {req_ready, req_ready0}, 2'b11);
      chk("hold release rsp_valid", {rsp_valid, rsp_valid0}, 0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || rsp_valid0 || !req_ready) seen = 1'b1;
      end
      chk("hold no second accept", seen, 1'b0);

      // Reset while the 2-cycle DUT is in WAIT and the 0-cycle DUT is in RESP.
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 8'd3;
      req_wdata = 16'hBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst pre rsp_valid0", rsp_valid0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst async rsp_valid", {rsp_valid, rsp_valid0}, 0);
      chk("rst async req_ready", {req_ready, req_ready0}, 2'b11);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (rsp_valid || rsp_valid0) seen = 1'b1;
      end
      chk("rst discarded rsp", seen, 1'b0);
      txn("ld3", 1'b0, 8'd3, 16'h0000, 16'hBEEF, 3'b100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
